// File: rtl/vga_stream_gen.sv
// VGA timing generator packing HS/VS/Active, pixel coordinates and colour into a 26-bit stream.
// Optional colour-bar test pattern enabled by defining VGA_TESTPATTERN_EN.
module vga_stream_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        px_clk,
    input  logic        px_rst_n,
    input  logic        en,
    input  logic [2:0]  bg_color,
    input  logic        pattern_sel,
    output logic [25:0] strRGB_o,
    output logic        frame_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Idle stream word: everything low except the sync pins at their inactive level.
    localparam logic [25:0] STR_RESET = {23'd0, ~HS_POL, ~VS_POL, 1'b0};

    logic [9:0]  hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    logic [25:0] str_q, str_d;
    logic        frame_q, frame_d;

    logic        active;
    logic        hs;
    logic        vs;
    logic [2:0]  color;
    logic [2:0]  rgb;

`ifdef VGA_TESTPATTERN_EN
    localparam logic [9:0] BAR_LAST = 10'(H_ACTIVE / 8 - 1);

    // bar_q/bar_cnt_q always describe the pixel at hc_q, so no divider is needed.
    logic [2:0]  bar_q, bar_d;
    logic [9:0]  bar_cnt_q, bar_cnt_d;
`else
    logic        unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
`endif

    always_comb begin
        hc_d    = hc_q;
        vc_d    = vc_q;
        str_d   = str_q;
        frame_d = 1'b0;

        active = (hc_q < H_ACT) && (vc_q < V_ACT);
        hs     = ((hc_q >= H_SS) && (hc_q < H_SE)) ? HS_POL : ~HS_POL;
        vs     = ((vc_q >= V_SS) && (vc_q < V_SE)) ? VS_POL : ~VS_POL;

`ifdef VGA_TESTPATTERN_EN
        color = pattern_sel ? bar_q : bg_color;
`else
        color = bg_color;
`endif
        rgb = active ? color : 3'b000;

        if (en) begin
            if (hc_q == H_LAST) begin
                hc_d = 10'd0;
                vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
            str_d   = {rgb, hc_q, vc_q, hs, vs, active};
            frame_d = (hc_q == 10'd0) && (vc_q == 10'd0);
        end
    end

`ifdef VGA_TESTPATTERN_EN
    always_comb begin
        bar_d     = bar_q;
        bar_cnt_d = bar_cnt_q;
        if (en) begin
            if (hc_d == 10'd0) begin
                bar_d     = 3'd0;
                bar_cnt_d = 10'd0;
            end else if ((bar_cnt_q == BAR_LAST) && (bar_q != 3'd7)) begin
                bar_d     = bar_q + 3'd1;
                bar_cnt_d = 10'd0;
            end else begin
                bar_cnt_d = bar_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge px_clk or negedge px_rst_n) begin
        if (!px_rst_n) begin
            bar_q     <= 3'd0;
            bar_cnt_q <= 10'd0;
        end else begin
            bar_q     <= bar_d;
            bar_cnt_q <= bar_cnt_d;
        end
    end
`endif

    always_ff @(posedge px_clk or negedge px_rst_n) begin
        if (!px_rst_n) begin
            hc_q    <= 10'd0;
            vc_q    <= 10'd0;
            str_q   <= STR_RESET;
            frame_q <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            str_q   <= str_d;
            frame_q <= frame_d;
        end
    end

    assign strRGB_o = str_q;
    assign frame_o  = frame_q;

endmodule

// File: tb/tb_vga_stream_gen.sv
// Directed bench for vga_stream_gen; vertical timing shortened so a whole frame fits the run.
module tb_vga_stream_gen;

    localparam int HA = 640;
    localparam int HF = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int VA = 20;
    localparam int VF = 2;
    localparam int VSY = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 800
    localparam int VT = VA + VF + VSY + VB;  // 27
    localparam int FRAME = HT * VT;          // 21600

    logic        px_clk;
    logic        px_rst_n;
    logic        en;
    logic [2:0]  bg_color;
    logic        pattern_sel;
    logic [25:0] strRGB_o;
    logic        frame_o;

    int checks;
    int errors;
    int hx, hy;   // counter state the next enabled edge will output
    int cx, cy;   // coordinates of the word currently on strRGB_o

    vga_stream_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .px_clk      (px_clk),
        .px_rst_n    (px_rst_n),
        .en          (en),
        .bg_color    (bg_color),
        .pattern_sel (pattern_sel),
        .strRGB_o    (strRGB_o),
        .frame_o     (frame_o)
    );

    // ---------------- clock / reset ----------------
    initial px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [25:0] exp_word(input int x, input int y, input logic [2:0] bg);
        logic       act;
        logic       hsl;
        logic       vsl;
        logic [2:0] rgb;
        logic [9:0] xs;
        logic [9:0] ys;
        act = (x < HA) && (y < VA);
        hsl = (x >= HA + HF && x < HA + HF + HS) ? 1'b0 : 1'b1;
        vsl = (y >= VA + VF && y < VA + VF + VSY) ? 1'b0 : 1'b1;
        rgb = act ? bg : 3'b000;
        xs = 10'(x);
        ys = 10'(y);
        return {rgb, xs, ys, hsl, vsl, act};
    endfunction

    // One enabled clock edge; samples at the following falling edge.
    task automatic step();
        cx = hx;
        cy = hy;
        if (hx == HT - 1) begin
            hx = 0;
            hy = (hy == VT - 1) ? 0 : hy + 1;
        end else begin
            hx = hx + 1;
        end
        @(posedge px_clk);
        @(negedge px_clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        px_rst_n    = 1'b0;
        en          = 1'b1;
        bg_color    = 3'b101;
        pattern_sel = 1'b0;
        hx = 0; hy = 0;
        repeat (3) @(negedge px_clk);
        checks++;
        if (strRGB_o !== 26'h0000006) begin
            errors++;
            $display("FAIL reset_word: got %h expected %h", strRGB_o, 26'h0000006);
        end
        checks++;
        if (frame_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame: got %b expected 0", frame_o);
        end
    endtask

    task automatic test_first_frame();
        logic exp_f;
        bg_color = 3'b101;
        px_rst_n = 1'b1;
        for (int k = 0; k <= FRAME; k++) begin
            step();
            if (k == 0) begin
                checks++;
                if (strRGB_o !== {3'b101, 20'd0, 3'b111}) begin
                    errors++;
                    $display("FAIL first_word: got %h expected %h", strRGB_o, {3'b101, 20'd0, 3'b111});
                end
            end
            checks++;
            if (strRGB_o !== exp_word(cx, cy, bg_color)) begin
                errors++;
                $display("FAIL frame_word x=%0d y=%0d: got %h expected %h",
                         cx, cy, strRGB_o, exp_word(cx, cy, bg_color));
            end
            exp_f = (k == 0) || (k == FRAME);
            checks++;
            if (frame_o !== exp_f) begin
                errors++;
                $display("FAIL frame_pulse k=%0d: got %b expected %b", k, frame_o, exp_f);
            end
        end
    endtask

    task automatic test_line_scan();
        logic chk;
        logic e_act;
        logic e_hs;
        for (int i = 0; i < HT; i++) begin
            if (hx == 200) bg_color = 3'b010;
            if (hx == 201) bg_color = 3'b101;
            step();
            chk = 1'b1;
            e_act = 1'b0;
            e_hs = 1'b1;
            case (cx)
                1:       begin e_act = 1'b1; e_hs = 1'b1; end
                639:     begin e_act = 1'b1; e_hs = 1'b1; end
                640:     begin e_act = 1'b0; e_hs = 1'b1; end
                655:     begin e_act = 1'b0; e_hs = 1'b1; end
                656:     begin e_act = 1'b0; e_hs = 1'b0; end
                751:     begin e_act = 1'b0; e_hs = 1'b0; end
                752:     begin e_act = 1'b0; e_hs = 1'b1; end
                799:     begin e_act = 1'b0; e_hs = 1'b1; end
                default: chk = 1'b0;
            endcase
            if (chk) begin
                checks++;
                if (strRGB_o[0] !== e_act || strRGB_o[2] !== e_hs) begin
                    errors++;
                    $display("FAIL line_act_hs x=%0d: got act=%b hs=%b expected act=%b hs=%b",
                             cx, strRGB_o[0], strRGB_o[2], e_act, e_hs);
                end
            end
            if (cx == 200) begin
                checks++;
                if (strRGB_o[25:23] !== 3'b010) begin
                    errors++;
                    $display("FAIL line_bg_change: got %b expected 010", strRGB_o[25:23]);
                end
            end
            if (cx == 201) begin
                checks++;
                if (strRGB_o[25:23] !== 3'b101) begin
                    errors++;
                    $display("FAIL line_bg_restore: got %b expected 101", strRGB_o[25:23]);
                end
            end
        end
        checks++;
        if (strRGB_o[22:13] !== 10'd0 || strRGB_o[12:3] !== 10'd1) begin
            errors++;
            $display("FAIL line_wrap: got xc=%0d yc=%0d expected xc=0 yc=1",
                     strRGB_o[22:13], strRGB_o[12:3]);
        end
    endtask

    task automatic test_en_hold();
        logic [25:0] held;
        for (int i = 0; i < HT && cx != 300; i++) step();
        checks++;
        if (cx != 300) begin
            errors++;
            $display("FAIL hold_reach: got x=%0d expected 300", cx);
        end
        held = exp_word(300, cy, 3'b101);
        en = 1'b0;
        bg_color = 3'b111;
        for (int i = 0; i < 37; i++) begin
            @(posedge px_clk);
            @(negedge px_clk);
            checks++;
            if (strRGB_o !== held || frame_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_frozen cyc=%0d: got %h/%b expected %h/0", i, strRGB_o, frame_o, held);
            end
        end
        en = 1'b1;
        bg_color = 3'b101;
        step();
        checks++;
        if (strRGB_o !== exp_word(301, cy, 3'b101)) begin
            errors++;
            $display("FAIL hold_resume: got %h expected %h", strRGB_o, exp_word(301, cy, 3'b101));
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < FRAME && !(cx == 500 && cy == 15); i++) step();
        checks++;
        if (strRGB_o !== exp_word(500, 15, 3'b101)) begin
            errors++;
            $display("FAIL rst_mid_before: got %h expected %h", strRGB_o, exp_word(500, 15, 3'b101));
        end
        #2 px_rst_n = 1'b0;
        #1;
        checks++;
        if (strRGB_o !== 26'h0000006 || frame_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got %h/%b expected 0000006/0", strRGB_o, frame_o);
        end
        repeat (2) @(negedge px_clk);
        px_rst_n = 1'b1;
        hx = 0; hy = 0;
        step();
        checks++;
        if (strRGB_o !== exp_word(0, 0, 3'b101) || frame_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_restart: got %h/%b expected %h/1", strRGB_o, frame_o, exp_word(0, 0, 3'b101));
        end
        step();
        checks++;
        if (strRGB_o !== exp_word(1, 0, 3'b101) || frame_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_next: got %h/%b expected %h/0", strRGB_o, frame_o, exp_word(1, 0, 3'b101));
        end
    endtask

    task automatic test_pattern();
        logic [2:0] e_rgb;
        int bar;
        for (int i = 0; i < FRAME && !(hx == 0 && hy == 10); i++) step();
        bg_color = 3'b110;
        pattern_sel = 1'b1;
        for (int i = 0; i < HT; i++) begin
            step();
`ifdef VGA_TESTPATTERN_EN
            bar = cx / (HA / 8);
            if (bar > 7) bar = 7;
            e_rgb = (cx < HA) ? 3'(bar) : 3'b000;
`else
            bar = 0;
            e_rgb = (cx < HA) ? 3'b110 : 3'b000;
`endif
            checks++;
            if (strRGB_o[25:23] !== e_rgb || strRGB_o[12:3] !== 10'd10) begin
                errors++;
                $display("FAIL pattern_on x=%0d y=%0d: got rgb=%b yc=%0d expected rgb=%b yc=10",
                         cx, cy, strRGB_o[25:23], strRGB_o[12:3], e_rgb);
            end
        end
        pattern_sel = 1'b0;
        for (int i = 0; i < 700; i++) begin
            step();
            e_rgb = (cx < HA) ? 3'b110 : 3'b000;
            checks++;
            if (strRGB_o[25:23] !== e_rgb) begin
                errors++;
                $display("FAIL pattern_off x=%0d: got %b expected %b", cx, strRGB_o[25:23], e_rgb);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_first_frame();
        test_line_scan();
        test_en_hold();
        test_reset_mid();
        test_pattern();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
